// File: rtl/aes_pkg.sv
// Shared widths, FSM encoding and byte-lane helper for the AES byte-stream loader.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W     = 128;
  localparam int unsigned AES_BYTES       = 16;
  localparam int unsigned AES_FRAME_BYTES = 32;
  localparam int unsigned AES_CNT_W       = 5;
  localparam int unsigned AES_LANE_W      = 7;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  // LSB position of byte lane n within a block; lane 0 is the most significant byte.
  function automatic logic [AES_LANE_W-1:0] byte_lsb(input logic [3:0] lane);
    return AES_LANE_W'(7'd120 - {lane, 3'b000});
  endfunction

endpackage

// File: rtl/aes_byte_packer.sv
// Byte counter and plaintext/key staging registers; flags frame completion and malformed frames.
// AES_KEY_REUSE_EN: in_last on byte 15 ends a legal plaintext-only frame.
module aes_byte_packer
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   accept,
  input  logic [7:0]             data,
  input  logic                   last,
  output logic [AES_BLOCK_W-1:0] pt,
  output logic [AES_BLOCK_W-1:0] key,
  output logic                   frame_done_c,
  output logic                   data_only_c,
  output logic                   err_c
);

  logic [AES_CNT_W-1:0]  byte_cnt;
  logic [AES_LANE_W-1:0] lsb;

  assign lsb = byte_lsb(byte_cnt[3:0]);

  // Byte 31 always closes the frame; in_last is only meaningful before that.
  always_comb begin
    frame_done_c = 1'b0;
    data_only_c  = 1'b0;
    err_c        = 1'b0;
    if (accept) begin
      if (byte_cnt == AES_CNT_W'(AES_FRAME_BYTES - 1)) begin
        frame_done_c = 1'b1;
      end else if (last) begin
`ifdef AES_KEY_REUSE_EN
        if (byte_cnt == AES_CNT_W'(AES_BYTES - 1)) begin
          frame_done_c = 1'b1;
          data_only_c  = 1'b1;
        end else begin
          err_c = 1'b1;
        end
`else
        err_c = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
      pt       <= '0;
      key      <= '0;
    end else if (accept) begin
      if (byte_cnt[4]) key[lsb +: 8] <= data;
      else             pt[lsb +: 8]  <= data;
      byte_cnt <= (frame_done_c || err_c) ? '0 : AES_CNT_W'(byte_cnt + 1'b1);
    end
  end

endmodule

// File: rtl/aes_stream_loader.sv
// Byte-stream front end for aesEncryption: stages a frame, holds core inputs, captures the ciphertext.
// AES_KEY_REUSE_EN: a 16-byte frame updates only core_datain and keeps the last key.
module aes_stream_loader
  import aes_pkg::*;
#(
  parameter int unsigned CORE_LATENCY = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  input  logic                   in_last,
  output logic [AES_BLOCK_W-1:0] core_datain,
  output logic [AES_BLOCK_W-1:0] core_key,
  input  logic [AES_BLOCK_W-1:0] core_dataout,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [AES_BLOCK_W-1:0] res_data,
  output logic                   busy,
  output logic                   frame_err
);

  localparam int unsigned LAT_W = 8;

  aes_state_e             state, state_nxt;
  logic [LAT_W-1:0]       lat_cnt, lat_cnt_nxt;
  logic                   commit, commit_nxt;
  logic                   commit_key, commit_key_nxt;
  logic                   in_ready_nxt, res_valid_nxt, busy_nxt, frame_err_nxt;
  logic [AES_BLOCK_W-1:0] res_data_nxt, core_datain_nxt, core_key_nxt;
  logic [AES_BLOCK_W-1:0] pt_stage, key_stage;
  logic                   accept, frame_done_c, data_only_c, err_c;

  assign accept = in_valid & in_ready;

  aes_byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .accept       (accept),
    .data         (in_data),
    .last         (in_last),
    .pt           (pt_stage),
    .key          (key_stage),
    .frame_done_c (frame_done_c),
    .data_only_c  (data_only_c),
    .err_c        (err_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      lat_cnt     <= '0;
      commit      <= 1'b0;
      commit_key  <= 1'b0;
      in_ready    <= 1'b1;
      res_valid   <= 1'b0;
      res_data    <= '0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
      core_datain <= '0;
      core_key    <= '0;
    end else begin
      state       <= state_nxt;
      lat_cnt     <= lat_cnt_nxt;
      commit      <= commit_nxt;
      commit_key  <= commit_key_nxt;
      in_ready    <= in_ready_nxt;
      res_valid   <= res_valid_nxt;
      res_data    <= res_data_nxt;
      busy        <= busy_nxt;
      frame_err   <= frame_err_nxt;
      core_datain <= core_datain_nxt;
      core_key    <= core_key_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    lat_cnt_nxt     = lat_cnt;
    commit_nxt      = 1'b0;
    commit_key_nxt  = commit_key;
    in_ready_nxt    = in_ready;
    res_valid_nxt   = res_valid;
    res_data_nxt    = res_data;
    busy_nxt        = busy;
    frame_err_nxt   = 1'b0;
    core_datain_nxt = core_datain;
    core_key_nxt    = core_key;
    case (state)
      LOAD: begin
        frame_err_nxt = err_c;
        if (frame_done_c) begin
          state_nxt      = WAIT;
          in_ready_nxt   = 1'b0;
          busy_nxt       = 1'b1;
          commit_nxt     = 1'b1;
          commit_key_nxt = ~data_only_c;
        end
      end
      WAIT: begin
        // First WAIT cycle commits staging; capture lands on the cycle the count would hit zero.
        if (commit) begin
          core_datain_nxt = pt_stage;
          if (commit_key) core_key_nxt = key_stage;
          lat_cnt_nxt = LAT_W'(CORE_LATENCY);
        end else if (lat_cnt <= LAT_W'(1)) begin
          lat_cnt_nxt   = '0;
          res_data_nxt  = core_dataout;
          res_valid_nxt = 1'b1;
          state_nxt     = DONE;
        end else begin
          lat_cnt_nxt = lat_cnt - LAT_W'(1);
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_nxt = 1'b0;
          in_ready_nxt  = 1'b1;
          busy_nxt      = 1'b0;
          state_nxt     = LOAD;
        end
      end
      default: begin
        state_nxt = LOAD;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_stream_loader.sv
// Scoreboard bench for aes_stream_loader with a behavioural fixed-latency core stand-in.
module tb_aes_stream_loader;

  localparam int L = 10;
  localparam logic [127:0] PT   = 128'h54776f204f6e65204e696e652054776f;
  localparam logic [127:0] KEY  = 128'h5468617473206d79204b756e67204675;
  localparam logic [127:0] CT   = 128'h29c3505f571420f6402299b31a02d73a;
  localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT3  = 128'hfedcba98765432100123456789abcdef;
  localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] BAD  = {4{32'hdeadbeef}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic [7:0]   in_data = 8'h00;
  logic [127:0] core_datain, core_key, core_dataout, res_data;
  logic         res_valid, busy, frame_err;
  logic         res_ready = 1'b1;

  int nvec = 0, nfail = 0, cyc = 0, last_acc = 0;

  typedef struct {
    logic [127:0] ct;
    int           t_last;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_stream_loader #(.CORE_LATENCY(L)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .core_datain  (core_datain),
    .core_key     (core_key),
    .core_dataout (core_dataout),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .busy         (busy),
    .frame_err    (frame_err)
  );

  // Core stand-in: the known-answer pair yields the real AES ciphertext, anything else a keyed mix.
  function automatic logic [127:0] ref_core(input logic [127:0] d, input logic [127:0] k);
    if (d == PT && k == KEY) return CT;
    return d ^ {k[63:0], k[127:64]} ^ 128'h5a5a;
  endfunction

  // Output is garbage until inputs have been stable for the full latency.
  logic [127:0] prev_d = '0, prev_k = '0;
  int stable = 0;
  always @(negedge clk) begin
    if (core_datain != prev_d || core_key != prev_k) begin
      stable = 0;
      prev_d = core_datain;
      prev_k = core_key;
    end else if (stable < 10000) begin
      stable++;
    end
  end
  assign core_dataout = (stable >= L - 1) ? ref_core(core_datain, core_key) : BAD;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: pops one expectation per result and checks data, latency and hold stability.
  bit           rv_prev = 1'b0;
  logic [127:0] held = '0;
  always @(negedge clk) begin
    exp_t e;
    if (res_valid && !rv_prev) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL unexpected_result: res_data %h with nothing expected", res_data);
      end else begin
        e = exp_q.pop_front();
        chk("res_data", res_data, e.ct);
        chk("latency", 128'(cyc - e.t_last), 128'(L + 1));
      end
      held = res_data;
    end else if (res_valid) begin
      chk("res_hold", res_data, held);
    end
    rv_prev = res_valid;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      nvec++;
      nfail++;
      $display("FAIL in_ready_timeout: in_ready still 0 after %0d cycles", n);
    end
    @(posedge clk);
    #1;
    last_acc = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [127:0] pt, input logic [127:0] key, input int nbytes,
                            input bit mark_last, input bit push, input bit gaps);
    logic [7:0] b;
    for (int i = 0; i < nbytes; i++) begin
      if (gaps && i > 0 && $urandom_range(1, 0) == 1) idle(1 + $urandom_range(2, 0));
      if (i < 16) b = 8'(pt >> (8 * (15 - i)));
      else        b = 8'(key >> (8 * (31 - i)));
      send_byte(b, mark_last && (i == nbytes - 1));
    end
    if (push) exp_q.push_back('{ct: ref_core(pt, key), t_last: last_acc});
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || res_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) begin
      nvec++;
      nfail++;
      $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_res_valid", 128'(res_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_frame_err", 128'(frame_err), 128'(0));
    chk("rst_res_data", res_data, 128'(0));
    chk("rst_core_datain", core_datain, 128'(0));
    chk("rst_core_key", core_key, 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [127:0] p, k;
    idle(2);
    do_reset();

    // Known-answer frame with exact latency.
    send_frame(PT, KEY, 32, 1'b1, 1'b1, 1'b0);
    drain();
    chk("t1_core_datain", core_datain, PT);
    chk("t1_core_key", core_key, KEY);

    // Back-pressure in DONE; in_valid must be ignored.
    res_ready = 1'b0;
    send_frame(PT2, KEY, 32, 1'b1, 1'b1, 1'b0);
    n = 0;
    while (!res_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t2_res_valid_seen", 128'(res_valid), 128'(1));
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom());
      @(negedge clk);
      chk("t2_in_ready_low", 128'(in_ready), 128'(0));
      chk("t2_busy_high", 128'(busy), 128'(1));
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t2_release_res_valid", 128'(res_valid), 128'(0));
    chk("t2_release_in_ready", 128'(in_ready), 128'(1));
    chk("t2_release_busy", 128'(busy), 128'(0));

    // Early in_last on byte 7.
    send_frame(PT3, KEY2, 8, 1'b1, 1'b0, 1'b0);
    chk("t3_frame_err_pulse", 128'(frame_err), 128'(1));
    idle(1);
    chk("t3_frame_err_clear", 128'(frame_err), 128'(0));
    chk("t3_core_datain_kept", core_datain, PT2);
    chk("t3_core_key_kept", core_key, KEY);
    send_frame(PT3, KEY2, 32, 1'b1, 1'b1, 1'b0);
    drain();

    // Reset mid-frame, then mid-WAIT; no result may appear.
    send_frame(PT, KEY, 20, 1'b0, 1'b0, 1'b0);
    do_reset();
    send_frame(PT, KEY, 32, 1'b1, 1'b0, 1'b0);
    idle(4);
    do_reset();
    idle(L + 5);
    chk("t4_no_result", 128'(res_valid), 128'(0));
    send_frame(PT2, KEY2, 32, 1'b1, 1'b1, 1'b0);
    drain();

    // 16-byte frame: key reuse when enabled, otherwise malformed.
`ifdef AES_KEY_REUSE_EN
    send_frame(PT, KEY, 32, 1'b1, 1'b1, 1'b0);
    drain();
    send_frame(PT, KEY, 16, 1'b1, 1'b1, 1'b0);
    chk("t5_no_err", 128'(frame_err), 128'(0));
    drain();
    do_reset();
    send_frame(PT2, 128'(0), 16, 1'b1, 1'b1, 1'b0);
    drain();
    chk("t5_zero_key", core_key, 128'(0));
`else
    send_frame(PT, KEY, 16, 1'b1, 1'b0, 1'b0);
    chk("t5_short_err", 128'(frame_err), 128'(1));
    idle(L + 3);
    chk("t5_short_no_result", 128'(res_valid), 128'(0));
`endif

    // Eight frames with random input gaps.
    for (int f = 0; f < 8; f++) begin
      p = {$urandom(), $urandom(), $urandom(), $urandom()};
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      send_frame(p, k, 32, 1'b1, 1'b1, 1'b1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
